imem_fetch_server: RTL and testbench

Instruction-memory responder for the fetch side of the core: accepts byte-addressed fetch requests from the CPU front end over a valid/ready handshake and returns 32-bit instruction words, in order, after a fixed pipelined read latency. It replaces the zero-latency combinational instruction ROM with a synchronous, backpressure-aware server. It also provides a program-load write port for boot code and testbenches.

---
 rtl/imem_fetch_server.sv | 154 +++++++++++++++
 tb/tb_imem_fetch_server.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_server.sv
// imem_fetch_server: synchronous instruction memory for the fetch front end.
// Requests are accepted over valid/ready, read in the accept cycle, carried
// through a fixed-latency pipeline and queued in an in-order response FIFO.
// The in-flight count caps acceptance, so the FIFO can never overflow.
// A program-load port writes words and blocks fetches while it is active.
module imem_fetch_server #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_instr,
    output logic                           rsp_fault,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data,
    output logic                           busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FD = LATENCY + 1;
    localparam int PW = $clog2(FD);
    localparam int CW = $clog2(FD + 1);

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept;
    logic          pop;
    logic          rd_fault;
    logic [31:0]   rd_instr;
    logic          push_valid;
    logic [31:0]   push_instr;
    logic          push_fault;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0]   fifo_instr_q [FD];
    logic          fifo_fault_q [FD];

    assign rd_fault  = (req_addr[1:0] != 2'b00) || (|req_addr[31:2+AW]);
    assign rd_instr  = rd_fault ? '0 : mem_q[req_addr[2 +: AW]];

    assign req_ready = (cnt_q < CW'(FD)) && !load_en;
    assign accept    = req_valid && req_ready;

    assign rsp_valid = (fill_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    // FIFO storage is not reset, so outputs are gated by the valid flag
    assign rsp_instr = rsp_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign rsp_fault = rsp_valid ? fifo_fault_q[rd_ptr_q] : 1'b0;
    assign busy      = (cnt_q != '0);

    // program-load writes; memory survives reset
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // The FIFO write is the last latency stage, so only LATENCY-1 registers
    // sit between the memory read and the FIFO.
    generate
        if (LATENCY == 1) begin : g_direct
            assign push_valid = accept;
            assign push_instr = rd_instr;
            assign push_fault = rd_fault;
        end else begin : g_pipe
            localparam int NS = LATENCY - 1;
            logic [NS-1:0] pv_q;
            logic [NS-1:0] pf_q;
            logic [31:0]   pi_q [NS];

            // shift pipeline carrying {valid, instr, fault}
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pv_q <= '0;
                    pf_q <= '0;
                    for (int i = 0; i < NS; i++) begin
                        pi_q[i] <= '0;
                    end
                end else begin
                    pv_q[0] <= accept;
                    pi_q[0] <= rd_instr;
                    pf_q[0] <= rd_fault;
                    for (int i = 1; i < NS; i++) begin
                        pv_q[i] <= pv_q[i-1];
                        pi_q[i] <= pi_q[i-1];
                        pf_q[i] <= pf_q[i-1];
                    end
                end
            end

            assign push_valid = pv_q[NS-1];
            assign push_instr = pi_q[NS-1];
            assign push_fault = pf_q[NS-1];
        end
    endgenerate

    // response FIFO storage
    always_ff @(posedge clk) begin
        if (push_valid) begin
            fifo_instr_q[wr_ptr_q] <= push_instr;
            fifo_fault_q[wr_ptr_q] <= push_fault;
        end
    end

    // next-state for pointers, FIFO fill and in-flight count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        if (push_valid) begin
            wr_ptr_d = (wr_ptr_q == PW'(FD - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FD - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push_valid, pop})
            2'b10:   fill_d = fill_q + CW'(1);
            2'b01:   fill_d = fill_q - CW'(1);
            default: fill_d = fill_q;
        endcase
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // control registers; reset discards everything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch_server.sv
// Scoreboard bench for imem_fetch_server (DEPTH_WORDS=256, LATENCY=2).
module tb_imem_fetch_server;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_fault;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic        busy;

    imem_fetch_server #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [DEPTH];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    bit          lat_chk = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Inputs change #1 after posedge, so at negedge they describe the coming edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_instr", rsp_instr, e.instr);
                    check("rsp_fault", 32'(rsp_fault), 32'(e.fault));
                    if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'(LAT));
                end
            end
            if (req_valid && req_ready) begin
                e.fault = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
                e.instr = e.fault ? 32'h0 : model_mem[req_addr[9:2]];
                e.cyc   = cyc;
                sb_q.push_back(e);
                acc_cnt++;
            end
            if (load_en) model_mem[load_addr] = load_data;
        end
    end

    task automatic load_word(input int idx, input logic [31:0] data);
        @(posedge clk); #1;
        load_en   = 1'b1;
        load_addr = 8'(idx);
        load_data = data;
        @(posedge clk); #1;
        load_en   = 1'b0;
    endtask

    // called #1 after a posedge; returns #1 after the accepting edge
    task automatic send(input logic [31:0] addr);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_addr  = addr;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk); #1;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        check("global_timeout", 32'd0, 32'd1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int a0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_instr", rsp_instr, 32'h0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) load_word(i, 32'h1000_0000 + 32'(i) * 32'h0001_1111);
        load_word(3, 32'h2002_0005);

        // single fetch
        lat_chk = 1'b1;
        send(32'h0000_000C);
        check("single_busy", 32'(busy), 32'd1);
        drain();

        // streaming, one request per cycle
        for (int i = 0; i < 16; i++) send(32'(i * 4));
        drain();
        lat_chk = 1'b0;

        // backpressure
        rsp_ready = 1'b0;
        a0 = acc_cnt;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'h20 + 32'(i * 4);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("bp_accepts", 32'(acc_cnt - a0), 32'(LAT + 1));
        check("bp_req_ready", 32'(req_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_head", rsp_instr, 32'h1000_0000 + 32'd8 * 32'h0001_1111);
        rsp_ready = 1'b1;
        check("full_req_ready", 32'(req_ready), 32'd0);
        drain();

        // faults around a good request
        send(32'h0000_0002);
        send(32'h0000_0010);
        send(32'h0000_0400);
        drain();

        // load collision: in-flight read keeps old word
        load_word(5, 32'hAAAA_AAAA);
        send(32'h0000_0014);
        load_en   = 1'b1;
        load_addr = 8'd5;
        load_data = 32'h5555_5555;
        #1;
        check("load_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        load_en = 1'b0;
        send(32'h0000_0014);
        drain();

        // reset mid-flight
        rsp_ready = 1'b0;
        send(32'h0000_000C);
        send(32'h0000_0010);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        sb_q.delete();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        send(32'h0000_000C);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
